// File: rtl/uncache_unit_pkg.sv
// Shared types for the uncached access unit: FSM states, access-size codes and
// the registered bus request bundle.
package uncache_unit_pkg;

    localparam int          ADDR_W_DEF     = 32;
    localparam int          DATA_W_DEF     = 32;
    localparam logic [31:0] PADDR_MASK_DEF = 32'h1FFF_FFFF;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic                  wr;
        logic [1:0]            size;
        logic [ADDR_W_DEF-1:0] addr;
        logic [3:0]            wstrb;
        logic [DATA_W_DEF-1:0] wdata;
    } bus_req_t;

    function automatic bus_req_t make_req(
        input logic                  wr,
        input logic [1:0]            size,
        input logic [ADDR_W_DEF-1:0] paddr,
        input logic [3:0]            wstrb,
        input logic [DATA_W_DEF-1:0] wdata
    );
        bus_req_t r;
        r.wr    = wr;
        r.size  = size;
        r.addr  = paddr;
        r.wstrb = wstrb;
        r.wdata = wdata;
        return r;
    endfunction

endpackage

// File: rtl/uncache_wbuf.sv
// One-entry posted-store buffer for the uncached unit; drains a single bus write
// and reports busy until its data phase completes (built only with UNCACHE_WBUF_EN).
`ifdef UNCACHE_WBUF_EN
module uncache_wbuf
    import uncache_unit_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  bus_req_t push_entry,
    input  logic     bus_addr_ok,
    input  logic     bus_data_ok,
    output logic     busy,
    output logic     bus_req,
    output bus_req_t entry
);

    logic     valid;
    logic     addr_pend;
    bus_req_t entry_q;

    // addr_ok and data_ok may coincide; the entry retires in that same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid     <= 1'b0;
            addr_pend <= 1'b0;
            entry_q   <= '0;
        end else if (push) begin
            valid     <= 1'b1;
            addr_pend <= 1'b1;
            entry_q   <= push_entry;
        end else if (valid) begin
            if (addr_pend && bus_addr_ok)
                addr_pend <= 1'b0;
            if (bus_data_ok && (!addr_pend || bus_addr_ok))
                valid <= 1'b0;
        end
    end

    assign busy    = valid;
    assign bus_req = valid && addr_pend;
    assign entry   = entry_q;

endmodule
`endif

// File: rtl/uncache_unit.sv
// Single uncached access engine on an SRAM-like bus (req/addr_ok/data_ok).
// Define UNCACHE_WBUF_EN to post stores through a one-entry write buffer.
module uncache_unit
    import uncache_unit_pkg::*;
#(
    parameter int               ADDR_W     = ADDR_W_DEF,
    parameter int               DATA_W     = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] PADDR_MASK = PADDR_MASK_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_uncache,
    input  logic              cpu_wr,
    input  logic [1:0]        cpu_size,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [3:0]        cpu_wstrb,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_wstrb,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata
);

    state_t            state, state_nxt;
    bus_req_t          req_q, new_req, bus_sel;
    logic              accept, capture, wbuf_busy;
    logic [DATA_W-1:0] rdata_q;

    assign new_req = make_req(cpu_wr, cpu_size, cpu_addr & PADDR_MASK, cpu_wstrb, cpu_wdata);

`ifdef UNCACHE_WBUF_EN
    logic     wbuf_push, wbuf_bus_req;
    bus_req_t wbuf_entry;

    uncache_wbuf u_wbuf (
        .clk         (clk),
        .rst         (rst),
        .push        (wbuf_push),
        .push_entry  (new_req),
        .bus_addr_ok (bus_addr_ok),
        .bus_data_ok (bus_data_ok),
        .busy        (wbuf_busy),
        .bus_req     (wbuf_bus_req),
        .entry       (wbuf_entry)
    );

    // Loads only start with the buffer empty, so the two bus masters never overlap.
    assign bus_sel = wbuf_busy ? wbuf_entry : req_q;
    assign bus_req = (state == REQ) || wbuf_bus_req;
`else
    assign wbuf_busy = 1'b0;
    assign bus_sel   = req_q;
    assign bus_req   = (state == REQ);
`endif

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path infers a latch.
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
`ifdef UNCACHE_WBUF_EN
        wbuf_push = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (cpu_req && cpu_uncache && !wbuf_busy) begin
                    accept    = 1'b1;
                    state_nxt = REQ;
`ifdef UNCACHE_WBUF_EN
                    if (cpu_wr) begin
                        wbuf_push = 1'b1;
                        state_nxt = DONE;
                    end
`endif
                end
            end
            REQ: begin
                if (bus_addr_ok) begin
                    if (bus_data_ok) begin
                        capture   = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (bus_data_ok) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            req_q   <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept)
                req_q <= new_req;
            if (capture && !req_q.wr)
                rdata_q <= bus_rdata;
        end
    end

    // Stall also covers a request held off by a draining buffered store.
    assign cpu_stall  = (state == REQ) || (state == WAIT) ||
                        ((state == IDLE) && cpu_req && cpu_uncache);
    assign cpu_rvalid = (state == DONE);
    assign cpu_rdata  = rdata_q;

    assign bus_wr    = bus_sel.wr;
    assign bus_size  = bus_sel.size;
    assign bus_addr  = bus_sel.addr;
    assign bus_wstrb = bus_sel.wstrb;
    assign bus_wdata = bus_sel.wdata;

endmodule

// File: tb/tb_uncache_unit.sv
// Self-checking bench for uncache_unit (default build): directed plan cases plus
// randomized transactions against a transaction-level expectation model.
module tb_uncache_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_uncache, cpu_wr;
    logic [1:0]  cpu_size;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [3:0]  cpu_wstrb;
    logic        cpu_stall, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        bus_req, bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_addr_ok, bus_data_ok;
    logic [31:0] bus_rdata;

    int          vectors    = 0;
    int          miscompares = 0;
    logic [31:0] exp_rdata  = 32'h0;

    uncache_unit dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_req     (cpu_req),
        .cpu_uncache (cpu_uncache),
        .cpu_wr      (cpu_wr),
        .cpu_size    (cpu_size),
        .cpu_addr    (cpu_addr),
        .cpu_wstrb   (cpu_wstrb),
        .cpu_wdata   (cpu_wdata),
        .cpu_stall   (cpu_stall),
        .cpu_rvalid  (cpu_rvalid),
        .cpu_rdata   (cpu_rdata),
        .bus_req     (bus_req),
        .bus_wr      (bus_wr),
        .bus_size    (bus_size),
        .bus_addr    (bus_addr),
        .bus_wstrb   (bus_wstrb),
        .bus_wdata   (bus_wdata),
        .bus_addr_ok (bus_addr_ok),
        .bus_data_ok (bus_data_ok),
        .bus_rdata   (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"},  cpu_stall,  0);
        check({tag, "_rvalid"}, cpu_rvalid, 0);
        check({tag, "_rdata"},  cpu_rdata,  0);
        check({tag, "_busreq"}, bus_req,    0);
        check({tag, "_buswr"},  bus_wr,     0);
        check({tag, "_bussize"}, bus_size,  0);
        check({tag, "_busaddr"}, bus_addr,  0);
        check({tag, "_buswstrb"}, bus_wstrb, 0);
        check({tag, "_buswdata"}, bus_wdata, 0);
    endtask

    // One full access: accept, a_dly cycles before addr_ok, data_ok d_dly cycles
    // after addr_ok (0 = same cycle), then the rvalid pulse and one idle cycle.
    task automatic do_txn(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                          input logic [3:0] wstrb, input logic [31:0] wdata,
                          input int a_dly, input int d_dly, input logic [31:0] rdata);
        logic [31:0] e_addr;
        e_addr = addr & 32'h1FFF_FFFF;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_uncache = 1'b1; cpu_wr = wr; cpu_size = size;
        cpu_addr = addr; cpu_wstrb = wstrb; cpu_wdata = wdata;
        @(negedge clk);
        check("accept_stall",  cpu_stall, 1);
        check("accept_busreq", bus_req,   0);
        for (int k = 0; k <= a_dly; k++) begin
            @(posedge clk); #1;
            cpu_req = 1'b0;
            cpu_wr = 1'($urandom); cpu_size = 2'($urandom_range(0, 2));
            cpu_addr = $urandom; cpu_wstrb = 4'($urandom); cpu_wdata = $urandom;
            bus_addr_ok = (k == a_dly);
            bus_data_ok = (k == a_dly) && (d_dly == 0);
            bus_rdata   = bus_data_ok ? rdata : $urandom;
            @(negedge clk);
            check("req_busreq", bus_req,   1);
            check("req_addr",   bus_addr,  e_addr);
            check("req_wr",     bus_wr,    wr);
            check("req_size",   bus_size,  size);
            check("req_wstrb",  bus_wstrb, wstrb);
            check("req_wdata",  bus_wdata, wdata);
            check("req_stall",  cpu_stall, 1);
            check("req_rvalid", cpu_rvalid, 0);
        end
        for (int j = 1; j <= d_dly; j++) begin
            @(posedge clk); #1;
            bus_addr_ok = 1'b0;
            bus_data_ok = (j == d_dly);
            bus_rdata   = bus_data_ok ? rdata : $urandom;
            @(negedge clk);
            check("wait_busreq", bus_req,    0);
            check("wait_stall",  cpu_stall,  1);
            check("wait_rvalid", cpu_rvalid, 0);
        end
        @(posedge clk); #1;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = $urandom;
        if (!wr) exp_rdata = rdata;
        @(negedge clk);
        check("done_rvalid", cpu_rvalid, 1);
        check("done_stall",  cpu_stall,  0);
        check("done_rdata",  cpu_rdata,  exp_rdata);
        check("done_busreq", bus_req,    0);
        @(posedge clk); #1;
        @(negedge clk);
        check("post_rvalid", cpu_rvalid, 0);
        check("post_stall",  cpu_stall,  0);
        check("post_rdata",  cpu_rdata,  exp_rdata);
    endtask

    initial begin
        rst = 1'b1;
        cpu_req = 1'b0; cpu_uncache = 1'b0; cpu_wr = 1'b0; cpu_size = 2'd0;
        cpu_addr = '0; cpu_wstrb = '0; cpu_wdata = '0;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
        #12;
        check_all_zero("reset");
        @(negedge clk); rst = 1'b0;

        // Load word, addr_ok and data_ok each a cycle late.
        do_txn(1'b0, 2'd2, 32'hBFAF_F000, 4'hF, 32'h0, 1, 2, 32'h1234_5678);
        // Store byte with addr_ok delayed 3 cycles.
        do_txn(1'b1, 2'd0, 32'hBFAF_0012, 4'b0100, 32'h00AB_0000, 3, 1, 32'hDEAD_BEEF);
        // Same-cycle addr_ok + data_ok: rvalid at cycle 2.
        do_txn(1'b0, 2'd1, 32'hBFAF_0104, 4'h3, 32'h0, 0, 0, 32'hCAFE_F00D);

        // Non-uncached request is ignored; a stray data_ok in IDLE is ignored too.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            cpu_req = 1'b1; cpu_uncache = 1'b0; cpu_wr = 1'b0; cpu_addr = 32'hBFAF_0200;
            bus_data_ok = (i == 1); bus_rdata = 32'h5555_AAAA;
            @(negedge clk);
            check("nouc_busreq", bus_req,    0);
            check("nouc_stall",  cpu_stall,  0);
            check("nouc_rvalid", cpu_rvalid, 0);
            check("nouc_rdata",  cpu_rdata,  exp_rdata);
        end
        @(posedge clk); #1;
        cpu_req = 1'b0; bus_data_ok = 1'b0;

        // Reset while in WAIT aborts everything.
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_uncache = 1'b1; cpu_wr = 1'b0; cpu_size = 2'd2;
        cpu_addr = 32'hBFAF_0300; cpu_wstrb = 4'hF; cpu_wdata = 32'h7777_7777;
        @(posedge clk); #1;
        cpu_req = 1'b0; bus_addr_ok = 1'b1;
        @(posedge clk); #1;
        bus_addr_ok = 1'b0;
        @(negedge clk);
        check("wait_pre_rst_stall",  cpu_stall, 1);
        check("wait_pre_rst_busreq", bus_req,   0);
        #1 rst = 1'b1;
        #1 check_all_zero("midrst");
        exp_rdata = 32'h0;
        @(negedge clk); rst = 1'b0;
        do_txn(1'b0, 2'd2, 32'hBFAF_0300, 4'hF, 32'h0, 0, 1, 32'h0BAD_C0DE);

        // Randomized transactions.
        for (int n = 0; n < 20; n++) begin
            do_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
                   {16'hBFAF, 16'($urandom)}, 4'($urandom), $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uncache_unit.md
Name: uncache_unit

Overview:
- Executes single uncached data accesses on behalf of the memory stage. It accepts a request only when the address-decode flag cpu_uncache (high for the 0xBFAF_xxxx device window) is set.
- Issues one SRAM-like bus transaction per accepted request (req/addr_ok/data_ok) and returns read data or a write completion.
- Sits directly downstream of the address-decode stage; its bus side is arbitrated with the D-cache refill port.

Parameters:
- ADDR_W, 32, CPU and bus address width.
- DATA_W, 32, data width.
- PADDR_MASK, 32'h1FFF_FFFF, virtual-to-physical mask for the kseg1 device window.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- cpu_req  in  1  memory-stage access valid
- cpu_uncache  in  1  address-decode flag; request accepted only if 1
- cpu_wr  in  1  1 = store, 0 = load
- cpu_size  in  2  0 = byte, 1 = half, 2 = word
- cpu_addr  in  ADDR_W  virtual address
- cpu_wstrb  in  4  byte enables (stores)
- cpu_wdata  in  DATA_W  store data
- cpu_stall  out  1  pipeline hold while the unit is busy
- cpu_rvalid  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  load data, valid with cpu_rvalid
- bus_req  out  1  bus request
- bus_wr, bus_size, bus_addr, bus_wstrb, bus_wdata  out  1/2/ADDR_W/4/DATA_W  registered request fields
- bus_addr_ok  in  1  request accepted by bus
- bus_data_ok  in  1  data phase done
- bus_rdata  in  DATA_W  read data

Behaviour:
- Reset values (asynchronous on rst high):
  - state = IDLE; all outputs 0, including bus_* fields and cpu_rdata.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If cpu_req && cpu_uncache, latch wr/size/wstrb/wdata, and bus_addr = cpu_addr & PADDR_MASK; go to REQ. cpu_stall rises combinationally in this same cycle.
  - cpu_req with cpu_uncache = 0 is ignored (no stall).
- REQ:
  - bus_req = 1 and fields held stable until bus_addr_ok.
  - On addr_ok, drop bus_req the next cycle and go to WAIT.
  - If addr_ok and data_ok arrive in the same cycle, capture data and go straight to DONE.
- WAIT:
  - Hold until bus_data_ok; then capture bus_rdata (loads only; stores leave cpu_rdata unchanged) and go to DONE.
  - data_ok never arrives in IDLE or DONE by bus protocol; if it does, it is ignored.
- DONE:
  - cpu_rvalid = 1 for exactly one cycle; cpu_stall = 0; return to IDLE.
  - A new request seen in DONE is not accepted until IDLE (one-cycle bubble).
- cpu_stall:
  - 1 in REQ and WAIT, and in IDLE on an accepting cycle.
  - 0 in DONE and otherwise.
- Minimum latency: accept cycle 0, bus_req cycles 1..n, rvalid at (data_ok cycle + 1). With zero-wait addr_ok/data_ok on cycle 1, rvalid is at cycle 2.
- Reset mid-transaction aborts to IDLE. The bus slave is reset in the same domain; no partial-transaction recovery.
- bus_size = cpu_size. bus_wstrb is passed through unchanged; the unit does no alignment check (exceptions are raised upstream).

Optional Feature:
- UNCACHE_WBUF_EN
- Defined:
  - Stores are posted: accepted in IDLE with cpu_rvalid pulsed the next cycle and no stall beyond the accept cycle.
  - The bus write drains from a one-entry buffer.
  - A subsequent request (load or store) stalls until the buffered write reaches data_ok, preserving device order.
- Undefined: stores behave exactly as loads (blocking until data_ok).

Decomposition:
- Shared package: state enum (IDLE/REQ/WAIT/DONE), size encodings (SIZE_B/H/W), PADDR_MASK default, and a bus-request struct bundling wr/size/addr/wstrb/wdata.
- Single module. With UNCACHE_WBUF_EN, the one-entry store buffer is the natural sub-module: uncache_wbuf.

Test Plan:
- Load word at 0xBFAF_F000, cpu_uncache = 1, addr_ok and data_ok each 1 cycle late, bus_rdata = 0x1234_5678 -> bus_addr = 0x1FAF_F000, bus_size = 2, one rvalid pulse with cpu_rdata = 0x1234_5678, stall deasserts in DONE.
- Store byte wstrb = 4'b0100, wdata = 0x00AB_0000, addr_ok delayed 3 cycles -> bus_req held with stable fields for 4 cycles, bus_wr = 1, rvalid after data_ok.
- Same-cycle addr_ok + data_ok on a load -> REQ to DONE directly, rvalid at cycle 2.
- cpu_req with cpu_uncache = 0 -> no bus_req, cpu_stall = 0.
- rst asserted while in WAIT -> immediate IDLE with all outputs 0; a following load completes normally.
- UNCACHE_WBUF_EN: store then load back-to-back -> store rvalid the next cycle, load stalls until the store's data_ok, bus order is store then load.
